// File: rtl/zbb_count_unit.sv
// ----------------------------------------------------------------------------
// zbb_count_unit
//
// Multi-cycle sequencer for the Zbb bit-count instructions CLZ, CTZ and CPOP.
// All three operations share one combinational leading-zero encoder:
//   - CLZ  : encoder applied directly to the operand.
//   - CTZ  : operand is bit-reversed on load, so trailing zeros become
//            leading zeros.
//   - CPOP : the encoder repeatedly locates the most-significant set bit,
//            which is then cleared while a counter increments. Latency is
//            therefore 2 + popcount(rs1) cycles from the accepting edge.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   kill        in   pipeline flush, aborts any in-flight operation
//   req_valid   in   request present
//   req_ready   out  unit can accept a request (IDLE only)
//   req_op      in   00 CLZ, 01 CTZ, 10 CPOP, 11 reserved (result 0)
//   req_rs1     in   source operand
//   rsp_valid   out  result available (DONE only)
//   rsp_ready   in   consumer takes the result
//   rsp_result  out  zero-extended count, stable while rsp_valid=1
//   busy        out  unit is in any state other than IDLE
//
// Also contains clz_encoder, the shared leading-zero counter.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// clz_encoder
//
// Purely combinational leading-zero count.
//   data_i  in   operand
//   lz_o    out  number of leading zeros, XLEN when data_i == 0
// ----------------------------------------------------------------------------
module clz_encoder #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic [XLEN-1:0]  data_i,
    output logic [CNT_W-1:0] lz_o
);

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned and no
        // latch is inferred.
        lz_o = CNT_W'(XLEN);
        // Scanning upward lets the highest set bit overwrite earlier hits,
        // leaving the position of the most-significant one.
        for (int i = 0; i < XLEN; i++) begin
            if (data_i[i]) begin
                lz_o = CNT_W'(XLEN - 1 - i);
            end
        end
    end

endmodule

// ----------------------------------------------------------------------------
// zbb_count_unit (top)
// ----------------------------------------------------------------------------
module zbb_count_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_CLZ  = 2'b00,
        OP_CTZ  = 2'b01,
        OP_CPOP = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    localparam logic [XLEN-1:0] MSB_ONE = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    op_t               op_q,    op_d;
    logic [XLEN-1:0]   work_q,  work_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   rs1_rev;
    logic [CNT_W-1:0]  lz;

    // ------------------------------------------------------------------
    // Shared encoder: always looks at the working register.
    // ------------------------------------------------------------------
    clz_encoder #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_clz (
        .data_i (work_q),
        .lz_o   (lz)
    );

    // Bit-reversed operand for CTZ: work[i] = rs1[XLEN-1-i].
    always_comb begin
        rs1_rev = '0;
        for (int i = 0; i < XLEN; i++) begin
            rs1_rev[i] = req_rs1[XLEN-1-i];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational blocks use blocking assignments so later
        // statements see the values computed above them in the same pass.
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (kill) begin
            // Flush wins over everything except reset; the partial result
            // is abandoned and result_q keeps its previous value.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_d  = op_t'(req_op);
                        cnt_d = '0;
                        unique case (op_t'(req_op))
                            OP_CLZ,
                            OP_CPOP: work_d = req_rs1;
                            OP_CTZ:  work_d = rs1_rev;
                            default: work_d = '0;
                        endcase
                        state_d = S_CALC;
                    end
                end

                S_CALC: begin
                    unique case (op_q)
                        OP_CLZ,
                        OP_CTZ: begin
                            result_d = {{(XLEN-CNT_W){1'b0}}, lz};
                            state_d  = S_DONE;
                        end
                        OP_CPOP: begin
                            if (work_q == '0) begin
                                result_d = {{(XLEN-CNT_W){1'b0}}, cnt_q};
                                state_d  = S_DONE;
                            end else begin
                                // lz < XLEN here, so the shifted one marks
                                // exactly the most-significant set bit.
                                work_d = work_q & ~(MSB_ONE >> lz);
                                // At most XLEN increments: never wraps.
                                cnt_d  = cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            result_d = '0;
                            state_d  = S_DONE;
                        end
                    endcase
                end

                S_DONE: begin
                    if (rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every register is reset, not only the FSM, because
        // result_q drives rsp_result directly and must read 0 after reset.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_CLZ;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decodes of registered state only, so nothing on req_*
    // reaches rsp_* within the same cycle.
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_result = result_q;

endmodule

// File: tb/tb_zbb_count_unit.sv
// ----------------------------------------------------------------------------
// tb_zbb_count_unit
//
// Self-checking bench for zbb_count_unit. Inputs change and outputs are
// sampled on the falling clock edge. Expected results and latencies come
// from a bit-scanning reference model of CLZ / CTZ / CPOP.
// ----------------------------------------------------------------------------
module tb_zbb_count_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kill;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zbb_count_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kill       (kill),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int ref_clz(input logic [31:0] x);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_ctz(input logic [31:0] x);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_pop(input logic [31:0] x);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x);
        case (op)
            2'd0:    return 32'(ref_clz(x));
            2'd1:    return 32'(ref_ctz(x));
            2'd2:    return 32'(ref_pop(x));
            default: return 32'd0;
        endcase
    endfunction

    // Edges from the accepting edge (inclusive) until rsp_valid is seen.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] x);
        return (op == 2'd2) ? 2 + ref_pop(x) : 2;
    endfunction

    // ------------------------------------------------------------------
    // One full transaction. Starts and ends on a falling edge with the
    // unit idle. hold = cycles rsp_ready stays low after rsp_valid.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs1,
                          input int hold, input string name);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        exp_res   = ref_result(op, rs1);
        exp_lat   = ref_latency(op, rs1);
        rsp_ready = (hold == 0);

        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
        end

        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        @(negedge clk);
        // Operands are sampled only at the accepting edge.
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_rs1   = $urandom;

        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end

        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (rsp_result !== exp_res) begin
            n_err++;
            $display("FAIL %s result: got %0d want %0d", name, rsp_result, exp_res);
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, exp_res}) begin
                n_err++;
                $display("FAIL %s hold cycle %0d: got valid=%b ready=%b result=%0d want valid=1 ready=0 result=%0d",
                         name, i, rsp_valid, req_ready, rsp_result, exp_res);
            end
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL %s return to idle: got valid=%b ready=%b busy=%b want 0 1 0",
                     name, rsp_valid, req_ready, busy);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        kill      = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_rs1   = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({req_ready, rsp_valid, busy, rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
                n_err++;
                $display("FAIL reset cycle %0d: got ready=%b valid=%b busy=%b result=%0d want 1 0 0 0",
                         i, req_ready, rsp_valid, busy, rsp_result);
            end
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset release: got ready=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_clz_ctz();
        run_op(2'd0, 32'h0001_0000, 0, "clz_0x00010000");
        run_op(2'd0, 32'h0000_0000, 0, "clz_0");
        run_op(2'd1, 32'h0001_0000, 0, "ctz_0x00010000");
        run_op(2'd1, 32'h0000_0000, 0, "ctz_0");
        run_op(2'd1, 32'h8000_0000, 0, "ctz_0x80000000");
        run_op(2'd0, 32'hFFFF_FFFF, 0, "clz_ones");
        run_op(2'd1, 32'h0000_0001, 0, "ctz_1");
    endtask

    task automatic test_cpop();
        run_op(2'd2, 32'h0000_0000, 0, "cpop_0");
        run_op(2'd2, 32'h8000_0001, 0, "cpop_0x80000001");
        run_op(2'd2, 32'hFFFF_FFFF, 0, "cpop_ones");
        run_op(2'd2, 32'hA5A5_A5A5, 0, "cpop_0xA5A5A5A5");
    endtask

    task automatic test_backpressure();
        run_op(2'd0, 32'h0000_0001, 5, "backpressure_clz_1");
        // Accepted on the cycle right after the return to IDLE.
        run_op(2'd1, 32'h0000_0100, 0, "after_backpressure");
    endtask

    task automatic test_kill();
        logic saw_valid;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_rs1   = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            saw_valid |= rsp_valid;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_cmp++;
        if ({busy, req_ready, rsp_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL kill to idle: got busy=%b ready=%b valid=%b want 0 1 0",
                     busy, req_ready, rsp_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_valid |= rsp_valid;
        end
        n_cmp++;
        if (saw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL kill rsp_valid seen: got %b want 0", saw_valid);
        end

        // kill outranks a request in IDLE
        kill      = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_rs1   = 32'h1;
        @(negedge clk);
        kill      = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL kill blocks accept: got busy=%b want 0", busy);
        end

        run_op(2'd0, 32'h0000_0100, 0, "clz_after_kill");
    endtask

    task automatic test_reserved_and_reset_mid();
        run_op(2'd3, 32'hFFFF_FFFF, 0, "reserved_op");

        req_valid = 1'b1;
        req_op    = 2'd2;
        req_rs1   = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, busy, rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset mid cpop: got ready=%b valid=%b busy=%b result=%0d want 1 0 0 0",
                     req_ready, rsp_valid, busy, rsp_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'd2, 32'h0000_00F0, 0, "cpop_after_reset");
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc;
        for (int i = 0; i < 6; i++) begin
            run_op(2'(i % 2), $urandom, 0, "b2b");
        end
        n_cmp++;
        if (cyc - start != 18) begin
            n_err++;
            $display("FAIL back_to_back cycles: got %0d want 18", cyc - start);
        end
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [1:0]  op;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       x = $urandom;
                1:       x = $urandom & $urandom & $urandom;
                2:       x = 32'h1 << $urandom_range(0, 31);
                3:       x = $urandom | $urandom;
                default: x = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
            run_op(op, x, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        kill      = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_rs1   = 32'd0;
        rsp_ready = 1'b1;
        @(negedge clk);

        test_reset();
        test_clz_ctz();
        test_cpop();
        test_backpressure();
        test_kill();
        test_reserved_and_reset_mid();
        test_back_to_back();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
